// File: rtl/CPU_package.sv
// Shared CPU definitions: datapath width, ALU opcode encoding and ALU flag layout.
package CPU_package;

    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_DIV = 4'b0011,
        OP_SHL = 4'b0100,
        OP_SHR = 4'b0101,
        OP_INC = 4'b0110,
        OP_DEC = 4'b0111,
        OP_AND = 4'b1000,
        OP_OR  = 4'b1001,
        OP_XOR = 4'b1010,
        OP_NOT = 4'b1011,
        OP_CPR = 4'b1100
    } enum_alu_opcode_t;

    // Flag word, MSB first: {carry, zero, negative, overflow, greater}
    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
        logic greater;
    } struct_alu_flag_t;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: combinational compute of result and flags feeding one output register.
module alu
    import CPU_package::*;
#(
    parameter int unsigned DATA_WIDTH = CPU_package::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  input_carry,
    input  enum_alu_opcode_t      alu_opcode,
    input  logic                  alu_mode,
    output logic [DATA_WIDTH-1:0] alu_out,
    output struct_alu_flag_t      alu_out_flag
);

    localparam int unsigned W   = DATA_WIDTH;
    localparam int unsigned WX  = DATA_WIDTH + 1;
    localparam int unsigned WW  = 2 * DATA_WIDTH;
    localparam int unsigned MSB = DATA_WIDTH - 1;

    logic [W-1:0]     op_b;
    logic             op_cin;
    logic [WX-1:0]    add_ext;
    logic [WX-1:0]    sub_ext;
    logic [WW-1:0]    prod;
    logic             valid;
    logic [W-1:0]     res;
    struct_alu_flag_t flag;

    // INC/DEC reuse the adder/subtractor with b = 1; carry-in only applies to ADD/SUB
    always_comb begin
        op_b   = in_b;
        op_cin = 1'b0;
        case (alu_opcode)
            OP_ADD, OP_SUB: op_cin = input_carry;
            OP_INC, OP_DEC: op_b   = W'(1);
            default: ;
        endcase
    end

    assign add_ext = {1'b0, in_a} + {1'b0, op_b} + WX'(op_cin);
    assign sub_ext = {1'b0, in_a} - {1'b0, op_b} - WX'(op_cin);
    assign prod    = WW'(in_a) * WW'(in_b);

    // Opcode bit 3 selects the group; the mode input must agree and reserved codes are rejected
    assign valid = (alu_mode == alu_opcode[3]) && (alu_opcode <= OP_CPR);

    always_comb begin
        res  = '0;
        flag = '0;
        if (valid) begin
            case (alu_opcode)
                OP_ADD, OP_INC: begin
                    res           = add_ext[W-1:0];
                    flag.carry    = add_ext[W];
                    flag.overflow = (in_a[MSB] == op_b[MSB]) && (res[MSB] != in_a[MSB]);
                end
                OP_SUB, OP_DEC: begin
                    res           = sub_ext[W-1:0];
                    flag.carry    = sub_ext[W];
                    flag.overflow = (in_a[MSB] != op_b[MSB]) && (res[MSB] != in_a[MSB]);
                end
                OP_MUL: begin
                    res        = prod[W-1:0];
                    flag.carry = |prod[WW-1:W];
                end
                OP_DIV: begin
                    if (in_b == '0) begin
                        res           = '1;
                        flag.overflow = 1'b1;
                    end else begin
                        res = in_a / in_b;
                    end
                end
                OP_SHL: begin
                    res        = {in_a[W-2:0], 1'b0};
                    flag.carry = in_a[MSB];
                end
                OP_SHR: begin
                    res        = {1'b0, in_a[W-1:1]};
                    flag.carry = in_a[0];
                end
                OP_AND: res = in_a & in_b;
                OP_OR:  res = in_a | in_b;
                OP_XOR: res = in_a ^ in_b;
                OP_NOT: res = ~in_a;
                OP_CPR: begin
                    res          = sub_ext[W-1:0];
                    flag.carry   = in_a < in_b;
                    flag.greater = in_a > in_b;
                end
                default: ;
            endcase
            flag.zero     = (res == '0);
            flag.negative = res[MSB];
        end
    end

    // Output register; reset clears immediately and drops any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out      <= '0;
            alu_out_flag <= '0;
        end else begin
            alu_out      <= res;
            alu_out_flag <= flag;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU: reset, mode gating, arithmetic, logic, compare, shifts.
module tb_alu;
    import CPU_package::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             input_carry;
    enum_alu_opcode_t alu_opcode;
    logic             alu_mode;
    logic [15:0]      alu_out;
    struct_alu_flag_t alu_out_flag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        enum_alu_opcode_t op;
        logic             mode;
        logic [15:0]      a;
        logic [15:0]      b;
        logic             cin;
        logic [15:0]      out;
        logic [4:0]       fl;
    } vec_t;

    alu dut (
        .clk          (clk),
        .rst          (rst),
        .in_a         (in_a),
        .in_b         (in_b),
        .input_carry  (input_carry),
        .alu_opcode   (alu_opcode),
        .alu_mode     (alu_mode),
        .alu_out      (alu_out),
        .alu_out_flag (alu_out_flag)
    );

    always #5 clk = ~clk;

    // Present one operation before a rising edge, return just after that edge
    task automatic drive(input enum_alu_opcode_t op, input logic mode,
                         input logic [15:0] a, input logic [15:0] b, input logic cin);
        @(negedge clk);
        alu_opcode  = op;
        alu_mode    = mode;
        in_a        = a;
        in_b        = b;
        input_carry = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu_opcode = OP_ADD; alu_mode = 1'b0; in_a = 16'd5; in_b = 16'd3; input_carry = 1'b0;
        #1;
        n_checks++;
        if ({alu_out, alu_out_flag} !== {16'h0, 5'b00000}) begin
            n_fail++;
            $display("FAIL reset_initial: got %h/%b want 0000/00000", alu_out, alu_out_flag);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({alu_out, alu_out_flag} !== {16'd8, 5'b00000}) begin
            n_fail++;
            $display("FAIL reset_first_op: got %h/%b want 0008/00000", alu_out, alu_out_flag);
        end
        @(negedge clk);
        in_a = 16'd100;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({alu_out, alu_out_flag} !== {16'h0, 5'b00000}) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%b want 0000/00000", alu_out, alu_out_flag);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({alu_out, alu_out_flag} !== {16'h0, 5'b00000}) begin
            n_fail++;
            $display("FAIL reset_held: got %h/%b want 0000/00000", alu_out, alu_out_flag);
        end
        @(negedge clk);
        rst = 1'b0;
        in_a = 16'd7; in_b = 16'd1;
        @(posedge clk); #1;
        n_checks++;
        if ({alu_out, alu_out_flag} !== {16'd8, 5'b00000}) begin
            n_fail++;
            $display("FAIL reset_release: got %h/%b want 0008/00000", alu_out, alu_out_flag);
        end
    endtask

    task automatic test_mode_mismatch();
        vec_t v[5] = '{
            '{OP_AND, 1'b0, 16'd1, 16'd1, 1'b0, 16'h0000, 5'b00000},
            '{OP_AND, 1'b1, 16'd1, 16'd0, 1'b0, 16'h0000, 5'b01000},
            '{OP_OR,  1'b1, 16'd1, 16'd0, 1'b0, 16'h0001, 5'b00000},
            '{OP_ADD, 1'b1, 16'd3, 16'd4, 1'b0, 16'h0000, 5'b00000},
            '{enum_alu_opcode_t'(4'b1101), 1'b1, 16'd3, 16'd4, 1'b0, 16'h0000, 5'b00000}
        };
        for (int i = 0; i < 5; i++) begin
            drive(v[i].op, v[i].mode, v[i].a, v[i].b, v[i].cin);
            n_checks++;
            if ({alu_out, alu_out_flag} !== {v[i].out, v[i].fl}) begin
                n_fail++;
                $display("FAIL mode_%0d: got %h/%b want %h/%b", i, alu_out, alu_out_flag, v[i].out, v[i].fl);
            end
        end
    endtask

    task automatic test_cpr();
        vec_t v[3] = '{
            '{OP_CPR, 1'b1, 16'd2,  16'd2,  1'b0, 16'h0000, 5'b01000},
            '{OP_CPR, 1'b1, 16'd20, 16'd10, 1'b0, 16'h000A, 5'b00001},
            '{OP_CPR, 1'b1, 16'd2,  16'd10, 1'b0, 16'hFFF8, 5'b10100}
        };
        for (int i = 0; i < 3; i++) begin
            drive(v[i].op, v[i].mode, v[i].a, v[i].b, v[i].cin);
            n_checks++;
            if ({alu_out, alu_out_flag} !== {v[i].out, v[i].fl}) begin
                n_fail++;
                $display("FAIL cpr_%0d: got %h/%b want %h/%b", i, alu_out, alu_out_flag, v[i].out, v[i].fl);
            end
        end
    endtask

    // Back-to-back: a new ADD every cycle, each result checked one edge later
    task automatic test_add_sweep();
        logic [15:0] exp_out;
        logic [4:0]  exp_fl;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 9; b++) begin
                drive(OP_ADD, 1'b0, 16'(a), 16'(b), 1'b0);
                exp_out = 16'(a + b);
                exp_fl  = (exp_out == 16'h0) ? 5'b01000 : 5'b00000;
                n_checks++;
                if ({alu_out, alu_out_flag} !== {exp_out, exp_fl}) begin
                    n_fail++;
                    $display("FAIL add_%0d_%0d: got %h/%b want %h/%b", a, b, alu_out, alu_out_flag, exp_out, exp_fl);
                end
            end
        end
    endtask

    task automatic test_arith_edges();
        vec_t v[9] = '{
            '{OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b11000},
            '{OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b00110},
            '{OP_ADD, 1'b0, 16'h0010, 16'h0020, 1'b1, 16'h0031, 5'b00000},
            '{OP_SUB, 1'b0, 16'd5,    16'd3,    1'b1, 16'h0001, 5'b00000},
            '{OP_SUB, 1'b0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 5'b10100},
            '{OP_SUB, 1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b00010},
            '{OP_INC, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 16'h0000, 5'b11000},
            '{OP_DEC, 1'b0, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, 5'b10100},
            '{OP_DEC, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 5'b00010}
        };
        for (int i = 0; i < 9; i++) begin
            drive(v[i].op, v[i].mode, v[i].a, v[i].b, v[i].cin);
            n_checks++;
            if ({alu_out, alu_out_flag} !== {v[i].out, v[i].fl}) begin
                n_fail++;
                $display("FAIL arith_%0d: got %h/%b want %h/%b", i, alu_out, alu_out_flag, v[i].out, v[i].fl);
            end
        end
    endtask

    task automatic test_shift_logic();
        vec_t v[8] = '{
            '{OP_SHR, 1'b0, 16'd4,    16'hFFFF, 1'b0, 16'h0002, 5'b00000},
            '{OP_SHL, 1'b0, 16'd4,    16'hFFFF, 1'b0, 16'h0008, 5'b00000},
            '{OP_SHL, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h0000, 5'b11000},
            '{OP_SHR, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 5'b11000},
            '{OP_XOR, 1'b1, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 5'b00000},
            '{OP_NOT, 1'b1, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 5'b00100},
            '{OP_AND, 1'b1, 16'hF00F, 16'h8FF1, 1'b1, 16'h8001, 5'b00100},
            '{OP_OR,  1'b1, 16'h0F00, 16'h00F0, 1'b1, 16'h0FF0, 5'b00000}
        };
        for (int i = 0; i < 8; i++) begin
            drive(v[i].op, v[i].mode, v[i].a, v[i].b, v[i].cin);
            n_checks++;
            if ({alu_out, alu_out_flag} !== {v[i].out, v[i].fl}) begin
                n_fail++;
                $display("FAIL shlog_%0d: got %h/%b want %h/%b", i, alu_out, alu_out_flag, v[i].out, v[i].fl);
            end
        end
    endtask

    task automatic test_mul_div();
        vec_t v[5] = '{
            '{OP_MUL, 1'b0, 16'd2,    16'd2,    1'b0, 16'h0004, 5'b00000},
            '{OP_MUL, 1'b0, 16'h0100, 16'h0100, 1'b0, 16'h0000, 5'b11000},
            '{OP_DIV, 1'b0, 16'd10,   16'd2,    1'b0, 16'h0005, 5'b00000},
            '{OP_DIV, 1'b0, 16'd10,   16'd3,    1'b0, 16'h0003, 5'b00000},
            '{OP_DIV, 1'b0, 16'd10,   16'd0,    1'b0, 16'hFFFF, 5'b00110}
        };
        for (int i = 0; i < 5; i++) begin
            drive(v[i].op, v[i].mode, v[i].a, v[i].b, v[i].cin);
            n_checks++;
            if ({alu_out, alu_out_flag} !== {v[i].out, v[i].fl}) begin
                n_fail++;
                $display("FAIL muldiv_%0d: got %h/%b want %h/%b", i, alu_out, alu_out_flag, v[i].out, v[i].fl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_mismatch();
        test_cpr();
        test_add_sweep();
        test_arith_edges();
        test_shift_logic();
        test_mul_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL use parameter DATA_WIDTH, default 16, operand/result width taken from CPU_package.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_a  input  DATA_WIDTH  operand A (unsigned unless stated).
REQ-005 SHALL have port in_b  input  DATA_WIDTH  operand B.
REQ-006 SHALL have port input_carry  input  1  carry-in for ADD and SUB.
REQ-007 SHALL have port alu_opcode  input  4 (enum_alu_opcode_t)  operation select.
REQ-008 SHALL have port alu_mode  input  1  group select: 0 = arithmetic/shift, 1 = logic/compare.
REQ-009 SHALL have port alu_out  output  DATA_WIDTH  registered result.
REQ-010 SHALL have port alu_out_flag  output  5 (struct_alu_flag_t)  registered flags {carry, zero, negative, overflow, greater}, MSB first.

Function
REQ-011 SHALL sample inputs on each rising clk and present result and flags after that edge (latency 1 cycle, no handshake, new operation every cycle).
REQ-012 SHALL use these opcode encodings: ADD 0000, SUB 0001, MUL 0010, DIV 0011, SHL 0100, SHR 0101, INC 0110, DEC 0111, AND 1000, OR 1001, XOR 1010, NOT 1011, CPR 1100; 1101-1111 reserved.
REQ-013 SHALL treat the operation as valid only when alu_mode equals alu_opcode[3] and the opcode is not reserved; otherwise alu_out = 0 and all flags = 0.
REQ-014 ADD: out = a + b + input_carry; carry = bit 16 of the sum; overflow = signed overflow.
REQ-015 SUB: out = a - b - input_carry; carry = borrow; overflow = signed overflow.
REQ-016 MUL: out = low 16 bits of the unsigned a*b; carry = 1 when the high 16 bits are non-zero.
REQ-017 DIV: out = a / b (unsigned, truncated); b = 0 gives out = 16'hFFFF with overflow = 1.
REQ-018 SHL: out = a << 1; carry = a[15]. SHR: logical, out = a >> 1; carry = a[0]. in_b is ignored for both.
REQ-019 INC: out = a + 1. DEC: out = a - 1. Carry and overflow for both are as for ADD/SUB with carry-in 0.
REQ-020 AND, OR, XOR: bitwise a op b. NOT: out = ~a. Carry and overflow SHALL be 0 for all four.
REQ-021 CPR: out = a - b (unsigned, wraps); carry = (a < b); zero = (a == b); greater = (a > b).
REQ-022 For every valid op: zero = (out == 0); negative = out[15]. Greater SHALL be 0 for every op except CPR.
REQ-023 Wrap-around SHALL be modulo 2^16 for all arithmetic; no saturation.

Reset
REQ-024 While rst is high, alu_out = 0 and alu_out_flag = 0 immediately, independent of clk.
REQ-025 The first rising clk after rst deasserts SHALL load the current operation; an operation in progress at reset SHALL be discarded.

Structure
REQ-026 CPU_package SHALL hold DATA_WIDTH, enum_alu_opcode_t and struct_alu_flag_t (packed, 5 bits), shared with the CPU.
REQ-027 SHALL be one module: a combinational compute block feeding one output register; no sub-modules.

Verification
REQ-028 Reset: assert rst mid-operation -> alu_out = 0, flags = 00000 without a clock edge.
REQ-029 Mode mismatch: mode 0, AND, a = 1, b = 1 -> out 0, flags 00000. Mode 1, AND, a = 1, b = 0 -> out 0, flags 01000. Mode 1, OR, a = 1, b = 0 -> out 1, flags 00000.
REQ-030 CPR, mode 1: a = 2, b = 2 -> out 0, flags 01000. a = 20, b = 10 -> out 10, flags 00001. a = 2, b = 10 -> out 16'hFFF8, flags 10100.
REQ-031 ADD sweep, mode 0: a = 0..15, b = 0..8, carry-in 0 -> out = a + b, one cycle later. 16'hFFFF + 1 -> out 0, flags 11000. 16'h7FFF + 1 -> out 16'h8000, flags 00110.
REQ-032 Shift: SHR a = 4 -> out 2. SHL a = 4 -> out 8. SHL a = 16'h8000 -> out 0, flags 11000.
REQ-033 MUL/DIV: MUL 2*2 -> out 4. DIV 10/2 -> out 5. DIV 10/0 -> out 16'hFFFF, flags 00110.
